// File: rtl/led_ctrl_pkg.sv
// Shared types and register layout for the LED controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_PRESC   = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_CH_BASE = 8'h10;

    localparam int CTRL_EN_BIT = 0;
    localparam int MODE_LSB    = 0;
    localparam int DUTY_LSB    = 8;
    localparam int HALF_LSB    = 16;

    // Word index (addr[7:2]) of channel i's register.
    function automatic logic [5:0] ch_idx(input int unsigned i);
        return OFF_CH_BASE[7:2] + i[5:0];
    endfunction

endpackage

// File: rtl/bus_if.sv
// Simple request/response register bus.
interface bus_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid, err);
    modport master (output req, we, addr, wdata, input gnt, rdata, rvalid, err);
endinterface

// File: rtl/led_ctrl_channel.sv
// One LED channel: config register, blink phase tracking and registered drive.
module led_ctrl_channel
    import led_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        tick_i,
    input  logic [7:0]  pwm_cnt_i,
    input  logic        wr_i,
    input  mode_e       mode_i,
    input  logic [7:0]  duty_i,
    input  logic [7:0]  half_i,
    output logic [31:0] cfg_o,
    output logic        led_o
);

    mode_e      mode_q;
    logic [7:0] duty_q, half_q, cnt_q, cnt_d;
    logic       phase_q, phase_d, led_q, led_d;
    logic [7:0] half_eff;

    assign half_eff = (half_q == 8'd0) ? 8'd1 : half_q;

    // A config write restarts the blink sequence and wins over a coinciding tick.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr_i || !en_i || mode_q != MODE_BLINK) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else if (tick_i) begin
            if (cnt_q + 8'd1 == half_eff) begin
                cnt_d   = 8'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        led_d = 1'b0;
        if (en_i) begin
            case (mode_q)
                MODE_ON:    led_d = 1'b1;
                MODE_BLINK: led_d = phase_q;
                MODE_PWM:   led_d = (pwm_cnt_i < duty_q);
                default:    led_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_OFF;
            duty_q  <= 8'd0;
            half_q  <= 8'd0;
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            if (wr_i) begin
                mode_q <= mode_i;
                duty_q <= duty_i;
                half_q <= half_i;
            end
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign cfg_o = {8'h00, half_q, duty_q, 6'h00, mode_q};
    assign led_o = led_q;

endmodule

// File: rtl/led_ctrl.sv
// LED controller top: register bus, shared prescaler and PWM counter, per-channel logic.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PRESC_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bus_if.slave                bus,
    output logic [NUM_LEDS-1:0] led_o
);

    logic               en_q;
    logic [PRESC_W-1:0] presc_q, presc_cnt_q;
    logic [7:0]         pwm_cnt_q;
    logic               rvalid_q, err_q;
    logic [31:0]        rdata_q;

    logic [5:0]          idx;
    logic                mapped, ctrl_wr, presc_wr, tick;
    logic [31:0]         rd_val;
    logic [NUM_LEDS-1:0] ch_wr;
    logic [31:0]         ch_cfg [NUM_LEDS];
    logic                unused_ok;

    assign idx       = bus.addr[7:2];
    assign unused_ok = ^{bus.addr[31:8], bus.addr[1:0], bus.wdata};
    assign ctrl_wr   = bus.req && bus.we && (idx == OFF_CTRL[7:2]);
    assign presc_wr  = bus.req && bus.we && (idx == OFF_PRESC[7:2]);
    assign tick      = en_q && (presc_cnt_q == presc_q);

    always_comb begin
        mapped = 1'b1;
        rd_val = 32'd0;
        ch_wr  = '0;
        case (idx)
            OFF_CTRL[7:2]:   rd_val = 32'(en_q);
            OFF_PRESC[7:2]:  rd_val = 32'(presc_q);
            OFF_STATUS[7:2]: rd_val = 32'(led_o);
            default:         mapped = 1'b0;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (idx == ch_idx(i)) begin
                mapped   = 1'b1;
                rd_val   = ch_cfg[i];
                ch_wr[i] = bus.req && bus.we;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q        <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= 8'd0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            if (ctrl_wr)  en_q    <= bus.wdata[CTRL_EN_BIT];
            if (presc_wr) presc_q <= bus.wdata[PRESC_W-1:0];

            if (!en_q || presc_wr || tick) presc_cnt_q <= '0;
            else                           presc_cnt_q <= presc_cnt_q + 1'b1;

            if (!en_q)     pwm_cnt_q <= 8'd0;
            else if (tick) pwm_cnt_q <= pwm_cnt_q + 8'd1;

            rvalid_q <= bus.req;
            err_q    <= bus.req && !mapped;
            rdata_q  <= (bus.req && !bus.we && mapped) ? rd_val : 32'd0;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_ctrl_channel u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_q),
            .tick_i    (tick),
            .pwm_cnt_i (pwm_cnt_q),
            .wr_i      (ch_wr[i]),
            .mode_i    (mode_e'(bus.wdata[MODE_LSB +: 2])),
            .duty_i    (bus.wdata[DUTY_LSB +: 8]),
            .half_i    (bus.wdata[HALF_LSB +: 8]),
            .cfg_o     (ch_cfg[i]),
            .led_o     (led_o[i])
        );
    end

    assign bus.gnt    = bus.req;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: register vector table through a response scoreboard, plus LED timing sequences.
module tb_led_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led;
    bus_if      bus ();

    exp_t sb [$];
    vec_t vecs [$];
    exp_t e_m;
    logic req_seen = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    led_ctrl #(.NUM_LEDS(4), .PRESC_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .led_o (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Response monitor: rvalid must follow each accepted request by one cycle.
    always @(posedge clk) req_seen <= bus.req && !rst;

    always @(negedge clk) begin
        if (req_seen || bus.rvalid) begin
            chk("rvalid_timing", 32'(bus.rvalid), 32'(req_seen));
            if (bus.rvalid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rvalid: actual=1 required=0");
                end else begin
                    e_m = sb.pop_front();
                    chk("rdata", bus.rdata, e_m.rdata);
                    chk("err", 32'(bus.err), 32'(e_m.err));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic count_led(input int bit_i, input int cycles, output int ones);
        ones = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (led[bit_i]) ones++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ones;
        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        rst = 1'b0;

        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'hFFFF_FFFF,  32'h0,          1'b0});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,          32'h0000_FFFF,  1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hFFFF_FFFF,  32'h0,          1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          32'h00FF_FF03,  1'b0});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,          32'h00FF_FF03,  1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FF10, 32'h0,          32'h00FF_FF03,  1'b0});
        vecs.push_back('{1'b1, 32'h0000_003C, 32'h1234_5678,  32'h0,          1'b1});
        vecs.push_back('{1'b0, 32'h0000_003C, 32'h0,          32'h0,          1'b1});
        vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,          32'h0,          1'b1});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,          32'h0,          1'b1});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,          32'h0000_FFFF,  1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          32'h00FF_FF03,  1'b0});
        vecs.push_back('{1'b1, 32'h0000_0008, 32'h0000_00FF,  32'h0,          1'b0});
        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'hFFFF_FFFE,  32'h0,          1'b0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'h0000_001C, 32'hFFAB_1206,  32'h0,          1'b0});
        vecs.push_back('{1'b0, 32'h0000_001C, 32'h0,          32'h00AB_1202,  1'b0});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'h0,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 32'h0,          32'h0,          1'b0});
        vecs.push_back('{1'b1, 32'h0000_001C, 32'h0,          32'h0,          1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,          32'h0,          1'b0});
        foreach (vecs[v])
            bus_op(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata, vecs[v].exp_err);

        // ON mode and EN gating
        bus_op(1'b1, 32'h00, 32'h1, 32'h0, 1'b0);
        bus_op(1'b1, 32'h10, 32'h1, 32'h0, 1'b0);
        chk("on_led_same_cycle", 32'(led[0]), 32'd0);
        @(negedge clk);
        chk("on_led_next_cycle", 32'(led[0]), 32'd1);
        bus_op(1'b0, 32'h08, 32'h0, 32'h1, 1'b0);
        bus_op(1'b1, 32'h00, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("en_off_led", 32'(led), 32'd0);
        bus_op(1'b1, 32'h10, 32'h0, 32'h0, 1'b0);

        // BLINK, half period 3 ticks at one tick per cycle; rewrite while phase is high
        bus_op(1'b1, 32'h04, 32'h0, 32'h0, 1'b0);
        bus_op(1'b1, 32'h00, 32'h1, 32'h0, 1'b0);
        bus_op(1'b1, 32'h14, 32'h0003_0002, 32'h0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("blink_led", 32'(led[1]), 32'(((k - 1) / 3) % 2));
        end
        bus_op(1'b1, 32'h14, 32'h0003_0002, 32'h0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("blink_restart_led", 32'(led[1]), 32'(((k - 1) / 3) % 2));
        end
        bus_op(1'b0, 32'h14, 32'h0, 32'h0003_0002, 1'b0);
        bus_op(1'b1, 32'h14, 32'h0, 32'h0, 1'b0);

        // PWM at PRESC=3: 1024-cycle period
        bus_op(1'b1, 32'h04, 32'h3, 32'h0, 1'b0);
        bus_op(1'b1, 32'h18, 32'h0000_4003, 32'h0, 1'b0);
        count_led(2, 1024, ones);
        chk("pwm_duty64_ones", 32'(ones), 32'd256);
        bus_op(1'b1, 32'h18, 32'h0000_FF03, 32'h0, 1'b0);
        count_led(2, 1024, ones);
        chk("pwm_duty255_ones", 32'(ones), 32'd1020);
        bus_op(1'b1, 32'h18, 32'h0000_0003, 32'h0, 1'b0);
        count_led(2, 1024, ones);
        chk("pwm_duty0_ones", 32'(ones), 32'd0);

        // Reset while blinking with a read in the same cycle
        bus_op(1'b1, 32'h04, 32'h0, 32'h0, 1'b0);
        bus_op(1'b1, 32'h10, 32'h1, 32'h0, 1'b0);
        bus_op(1'b1, 32'h14, 32'h0003_0002, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_led0", 32'(led[0]), 32'd1);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h10;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rst     = 1'b0;
        bus.req = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
        bus_op(1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
        bus_op(1'b0, 32'h14, 32'h0, 32'h0, 1'b0);
        bus_op(1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_led", 32'(led), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
